// File: rtl/tree_router_buffered.sv
// tree_router_buffered: 3-port binary-tree NoC router (children C1, C2 and parent P).
// Every input has a DEPTH-entry FIFO. Every output has a registered stage fed by a 2-way
// round-robin arbiter. Flits carry the destination in their top ADDR_W bits and even parity
// in bit 0. Flits leaving on C1/C2 can be parity-checked.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   {c1,c2,p}_in_valid/data/ready    input handshakes; ready = FIFO not full
//   {c1,c2,p}_out_valid/data/ready   output handshakes; valid = output register occupied
//   err_c1, err_c2                   1-cycle pulse after a C1/C2 output transfer with bad parity
//   err_cnt                          saturating parity error count
//   err_clr                          synchronous clear of err_cnt
module tree_router_buffered #(
  parameter int unsigned       DATA_W       = 9,
  parameter int unsigned       ADDR_W       = 4,
  parameter logic [ADDR_W-1:0] ADDRESS      = '0,
  parameter int unsigned       PREFIX_LEN   = 0,
  parameter int unsigned       DEPTH        = 4,
  parameter bit                CHECK_PARITY = 1'b1,
  parameter int unsigned       CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c1_in_valid,
  input  logic [DATA_W-1:0] c1_in_data,
  output logic              c1_in_ready,
  input  logic              c2_in_valid,
  input  logic [DATA_W-1:0] c2_in_data,
  output logic              c2_in_ready,
  input  logic              p_in_valid,
  input  logic [DATA_W-1:0] p_in_data,
  output logic              p_in_ready,
  output logic              c1_out_valid,
  output logic [DATA_W-1:0] c1_out_data,
  input  logic              c1_out_ready,
  output logic              c2_out_valid,
  output logic [DATA_W-1:0] c2_out_data,
  input  logic              c2_out_ready,
  output logic              p_out_valid,
  output logic [DATA_W-1:0] p_out_data,
  input  logic              p_out_ready,
  output logic              err_c1,
  output logic              err_c2,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              err_clr
);

  localparam int unsigned       AW         = $clog2(DEPTH);
  localparam logic [AW:0]       FullCnt    = (AW+1)'(DEPTH);
  localparam logic [AW:0]       CntOne     = (AW+1)'(1);
  localparam logic [AW-1:0]     PtrOne     = AW'(1);
  // Only the top PREFIX_LEN address bits take part in the subtree match.
  localparam logic [ADDR_W-1:0] PrefixMask = ~({ADDR_W{1'b1}} >> PREFIX_LEN);
  localparam int unsigned       SelIdx     = ADDR_W - 1 - PREFIX_LEN;

  // Index 0 = C1, 1 = C2, 2 = P for both inputs and outputs.
  logic [2:0]        in_valid, in_ready, push, pop, nonempty;
  logic [DATA_W-1:0] in_data [3];
  logic [DATA_W-1:0] head    [3];
  logic [2:0]        out_valid, out_ready;
  logic [DATA_W-1:0] out_data [3];
  logic [2:0][2:0]   gnt;     // gnt[output][input]
  logic [2:0]        req [3]; // req[input][output]
  logic [ADDR_W-1:0] dest [3];
  logic [2:0]        match;

  assign in_valid   = {p_in_valid, c2_in_valid, c1_in_valid};
  assign in_data[0] = c1_in_data;
  assign in_data[1] = c2_in_data;
  assign in_data[2] = p_in_data;
  assign out_ready  = {p_out_ready, c2_out_ready, c1_out_ready};

  assign c1_in_ready = in_ready[0];
  assign c2_in_ready = in_ready[1];
  assign p_in_ready  = in_ready[2];

  // Input FIFOs
  for (genvar g = 0; g < 3; g++) begin : gen_fifo
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     rd_q, wr_q;
    logic [AW:0]       cnt_q;

    assign in_ready[g] = (cnt_q != FullCnt);
    assign nonempty[g] = (cnt_q != '0);
    assign push[g]     = in_valid[g] & in_ready[g];
    assign head[g]     = mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push[g]) wr_q <= wr_q + PtrOne;
        if (pop[g])  rd_q <= rd_q + PtrOne;
        if (push[g] && !pop[g]) begin
          cnt_q <= cnt_q + CntOne;
        end else if (!push[g] && pop[g]) begin
          cnt_q <= cnt_q - CntOne;
        end
      end
    end

    // Storage needs no reset: the emptied count hides stale entries.
    always_ff @(posedge clk) begin
      if (push[g]) mem_q[wr_q] <= in_data[g];
    end
  end

  // Route decision on each FIFO head, one-hot over outputs.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dest[i]  = head[i][DATA_W-1 -: ADDR_W];
      match[i] = ((dest[i] ^ ADDRESS) & PrefixMask) == '0;
    end
    req[0] = '0;
    req[1] = '0;
    req[2] = '0;
    if (nonempty[0]) req[0] = match[0] ? 3'b010 : 3'b100;
    if (nonempty[1]) req[1] = match[1] ? 3'b001 : 3'b100;
    if (nonempty[2]) req[2] = dest[2][SelIdx] ? 3'b010 : 3'b001;
  end

  // Output stages: src0/src1 are the two inputs that can reach this output.
  for (genvar o = 0; o < 3; o++) begin : gen_out
    localparam int unsigned S0 = (o == 0) ? 1 : 0;
    localparam int unsigned S1 = (o == 2) ? 1 : 2;

    logic              last_q, vld_q;
    logic [DATA_W-1:0] data_q;
    logic              r0, r1, load, g0, g1;

    assign r0   = req[S0][o];
    assign r1   = req[S1][o];
    assign load = !vld_q || out_ready[o];
    // last_q = 0 favours src1 on contention, last_q = 1 favours src0.
    assign g0   = load & r0 & (!r1 | last_q);
    assign g1   = load & r1 & (!r0 | !last_q);
    assign gnt[o] = ({2'b00, g0} << S0) | ({2'b00, g1} << S1);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        last_q <= 1'b0;
        vld_q  <= 1'b0;
        data_q <= '0;
      end else if (load) begin
        vld_q <= g0 | g1;
        if (g0 || g1) data_q <= g0 ? head[S0] : head[S1];
        if (r0 && r1) last_q <= !last_q;
      end
    end

    assign out_valid[o] = vld_q;
    assign out_data[o]  = data_q;
  end

  assign pop = gnt[0] | gnt[1] | gnt[2];

  assign c1_out_valid = out_valid[0];
  assign c1_out_data  = out_data[0];
  assign c2_out_valid = out_valid[1];
  assign c2_out_data  = out_data[1];
  assign p_out_valid  = out_valid[2];
  assign p_out_data   = out_data[2];

  // Parity check on completed child-bound transfers.
  logic [1:0]       perr;
  logic             err_c1_q, err_c2_q;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W:0]   err_sum;

  always_comb begin
    for (int o = 0; o < 2; o++) begin
      perr[o] = CHECK_PARITY && out_valid[o] && out_ready[o] &&
                ((^out_data[o][DATA_W-1:1]) != out_data[o][0]);
    end
    // Clear and new errors on the same edge leave only the new errors.
    err_sum   = {1'b0, (err_clr ? '0 : err_cnt_q)} + (CNT_W+1)'(perr[0]) +
                (CNT_W+1)'(perr[1]);
    err_cnt_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_c1_q  <= 1'b0;
      err_c2_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_c1_q  <= perr[0];
      err_c2_q  <= perr[1];
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_c1  = err_c1_q;
  assign err_c2  = err_c2_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_tree_router_buffered.sv
module tb_tree_router_buffered;

  localparam int         DW    = 9;
  localparam int         AW    = 4;
  localparam int         PL    = 1;
  localparam int         DEPTH = 4;
  localparam int         CW    = 8;
  localparam logic [3:0] ADDR  = 4'b1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c1_in_valid, c2_in_valid, p_in_valid;
  logic [DW-1:0] c1_in_data, c2_in_data, p_in_data;
  logic          c1_in_ready, c2_in_ready, p_in_ready;
  logic          c1_out_valid, c2_out_valid, p_out_valid;
  logic [DW-1:0] c1_out_data, c2_out_data, p_out_data;
  logic          c1_out_ready, c2_out_ready, p_out_ready;
  logic          err_c1, err_c2, err_clr;
  logic [CW-1:0] err_cnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  tree_router_buffered #(
    .DATA_W(DW), .ADDR_W(AW), .ADDRESS(ADDR), .PREFIX_LEN(PL),
    .DEPTH(DEPTH), .CHECK_PARITY(1'b1), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .c1_in_valid(c1_in_valid), .c1_in_data(c1_in_data), .c1_in_ready(c1_in_ready),
    .c2_in_valid(c2_in_valid), .c2_in_data(c2_in_data), .c2_in_ready(c2_in_ready),
    .p_in_valid(p_in_valid), .p_in_data(p_in_data), .p_in_ready(p_in_ready),
    .c1_out_valid(c1_out_valid), .c1_out_data(c1_out_data), .c1_out_ready(c1_out_ready),
    .c2_out_valid(c2_out_valid), .c2_out_data(c2_out_data), .c2_out_ready(c2_out_ready),
    .p_out_valid(p_out_valid), .p_out_data(p_out_data), .p_out_ready(p_out_ready),
    .err_c1(err_c1), .err_c2(err_c2), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  // ---------------- reference model: queues per input, one slot per output ----------------
  logic [DW-1:0] mq [3][$];
  bit            m_oval [3];
  logic [DW-1:0] m_odata [3];
  bit            m_last [3];
  bit [1:0]      m_err;
  int            m_cnt;

  // Output index (0 C1, 1 C2, 2 P) a flit at the head of input src heads for.
  function automatic int route(int src, logic [DW-1:0] f);
    logic [3:0] d;
    bit         m;
    d = f[DW-1 -: AW];
    m = (d >> (AW - PL)) == (ADDR >> (AW - PL));
    if (src == 0) return m ? 1 : 2;
    if (src == 1) return m ? 0 : 2;
    return d[AW-1-PL] ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mq[i].delete();
        m_oval[i]  = 1'b0;
        m_odata[i] = '0;
        m_last[i]  = 1'b0;
      end
      m_err = '0;
      m_cnt = 0;
    end else begin
      bit [2:0]      iv, ordy, rdy, popf;
      logic [DW-1:0] id [3];
      int            tgt [3];
      bit [1:0]      e;
      int            s0, s1, pick;
      bit            r0, r1;
      iv    = {p_in_valid, c2_in_valid, c1_in_valid};
      ordy  = {p_out_ready, c2_out_ready, c1_out_ready};
      id[0] = c1_in_data;
      id[1] = c2_in_data;
      id[2] = p_in_data;
      for (int i = 0; i < 3; i++) begin
        rdy[i] = mq[i].size() < DEPTH;
        tgt[i] = (mq[i].size() > 0) ? route(i, mq[i][0]) : -1;
      end
      for (int o = 0; o < 2; o++)
        e[o] = m_oval[o] && ordy[o] && ((^m_odata[o][DW-1:1]) != m_odata[o][0]);
      popf = '0;
      for (int o = 0; o < 3; o++) begin
        s0 = (o == 0) ? 1 : 0;
        s1 = (o == 2) ? 1 : 2;
        r0 = (tgt[s0] == o);
        r1 = (tgt[s1] == o);
        if (!m_oval[o] || ordy[o]) begin
          pick = -1;
          if (r0 && r1) begin
            pick = m_last[o] ? s0 : s1;
            m_last[o] = !m_last[o];
          end else if (r0) pick = s0;
          else if (r1) pick = s1;
          if (pick >= 0) begin
            m_oval[o]  = 1'b1;
            m_odata[o] = mq[pick][0];
            popf[pick] = 1'b1;
          end else begin
            m_oval[o] = 1'b0;
          end
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (popf[i]) void'(mq[i].pop_front());
        if (iv[i] && rdy[i]) mq[i].push_back(id[i]);
      end
      m_err = e;
      m_cnt = (err_clr ? 0 : m_cnt) + int'(e[0]) + int'(e[1]);
      if (m_cnt > 255) m_cnt = 255;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c1_in_valid = 0; c2_in_valid = 0; p_in_valid = 0;
    c1_in_data = '0; c2_in_data = '0; p_in_data = '0;
    c1_out_ready = 1; c2_out_ready = 1; p_out_ready = 1;
    err_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    n_total++;
    if ({c1_out_valid, c2_out_valid, p_out_valid} !== 3'b000)
      $display("FAIL reset_valid: got %b want 000", {c1_out_valid, c2_out_valid, p_out_valid});
    else n_pass++;
    n_total++;
    if ({err_c1, err_c2} !== 2'b00) $display("FAIL reset_err: got %b want 00", {err_c1, err_c2});
    else n_pass++;
    n_total++;
    if (err_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", err_cnt);
    else n_pass++;
    step();
    rst_n = 1;
    step();
    n_total++;
    if ({c1_in_ready, c2_in_ready, p_in_ready} !== 3'b111)
      $display("FAIL reset_ready: got %b want 111", {c1_in_ready, c2_in_ready, p_in_ready});
    else n_pass++;
  endtask

  task automatic test_route_c1();
    c1_in_valid = 1;
    c1_in_data  = 9'h154;
    step();
    c1_in_valid = 0;
    step();
    n_total++;
    if (!(c2_out_valid === 1'b1 && c2_out_data === 9'h154))
      $display("FAIL route_c1_c2: got v=%b d=%h want v=1 d=154", c2_out_valid, c2_out_data);
    else n_pass++;
    n_total++;
    if ({c1_out_valid, p_out_valid} !== 2'b00)
      $display("FAIL route_c1_other: got %b want 00", {c1_out_valid, p_out_valid});
    else n_pass++;
    step();
    n_total++;
    if (err_c2 !== 1'b0) $display("FAIL route_c1_err: got %b want 0", err_c2);
    else n_pass++;
  endtask

  task automatic test_route_p();
    p_in_valid = 1;
    p_in_data  = 9'h154;
    step();
    p_in_valid = 0;
    step();
    n_total++;
    if (!(c1_out_valid === 1'b1 && c1_out_data === 9'h154 && c2_out_valid === 1'b0))
      $display("FAIL route_p_c1: got v1=%b d=%h v2=%b want v1=1 d=154 v2=0",
               c1_out_valid, c1_out_data, c2_out_valid);
    else n_pass++;
    p_in_valid = 1;
    p_in_data  = 9'h1D4;
    step();
    p_in_valid = 0;
    step();
    n_total++;
    if (!(c2_out_valid === 1'b1 && c2_out_data === 9'h1D4 && c1_out_valid === 1'b0))
      $display("FAIL route_p_c2: got v2=%b d=%h v1=%b want v2=1 d=1d4 v1=0",
               c2_out_valid, c2_out_data, c1_out_valid);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] got [$];
    logic [DW-1:0] exp [$];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp.push_back(9'h0C0 + DW'(k));
      exp.push_back(9'h100 + DW'(k));
    end
    for (int cyc = 0; cyc < 16; cyc++) begin
      c1_in_valid = (cyc < 4);
      p_in_valid  = (cyc < 4);
      c1_in_data  = 9'h100 + DW'(cyc);
      p_in_data   = 9'h0C0 + DW'(cyc);
      step();
      if (c2_out_valid) got.push_back(c2_out_data);
    end
    n_total++;
    if (got.size() !== 8) $display("FAIL rr_count: got %0d want 8", got.size());
    else n_pass++;
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      n_total++;
      if (got[k] !== exp[k]) $display("FAIL rr_order[%0d]: got %h want %h", k, got[k], exp[k]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got [$];
    int  k;
    bit  acc;
    do_reset();
    c2_out_ready = 0;
    k = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      c1_in_valid = 1;
      c1_in_data  = 9'h100 + DW'(k);
      acc = c1_in_ready;
      step();
      if (acc) k++;
    end
    c1_in_valid = 0;
    n_total++;
    if (k !== 5) $display("FAIL bp_accepted: got %0d want 5", k);
    else n_pass++;
    n_total++;
    if (c1_in_ready !== 1'b0) $display("FAIL bp_ready: got %b want 0", c1_in_ready);
    else n_pass++;
    c2_out_ready = 1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (c2_out_valid) got.push_back(c2_out_data);
      step();
    end
    n_total++;
    if (got.size() !== 5) $display("FAIL bp_delivered: got %0d want 5", got.size());
    else n_pass++;
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      n_total++;
      if (got[i] !== 9'h100 + DW'(i))
        $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], 9'h100 + DW'(i));
      else n_pass++;
    end
  endtask

  task automatic test_parity();
    do_reset();
    c1_in_valid = 1;
    c1_in_data  = 9'h155;
    step();
    c1_in_valid = 0;
    step();
    n_total++;
    if (!(c2_out_valid === 1'b1 && c2_out_data === 9'h155 && err_c2 === 1'b0))
      $display("FAIL par_deliver: got v=%b d=%h e=%b want v=1 d=155 e=0",
               c2_out_valid, c2_out_data, err_c2);
    else n_pass++;
    step();
    n_total++;
    if (!(err_c2 === 1'b1 && err_c1 === 1'b0 && err_cnt === 8'd1))
      $display("FAIL par_pulse: got e2=%b e1=%b cnt=%0d want e2=1 e1=0 cnt=1",
               err_c2, err_c1, err_cnt);
    else n_pass++;
    step();
    n_total++;
    if (!(err_c2 === 1'b0 && err_cnt === 8'd1))
      $display("FAIL par_once: got e2=%b cnt=%0d want e2=0 cnt=1", err_c2, err_cnt);
    else n_pass++;
    err_clr = 1;
    step();
    err_clr = 0;
    n_total++;
    if (err_cnt !== 8'd0) $display("FAIL par_clear: got %0d want 0", err_cnt);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    // Both children send bad-parity flits to each other every cycle.
    c1_in_valid = 1;
    c1_in_data  = 9'h155;
    c2_in_valid = 1;
    c2_in_data  = 9'h155;
    step();
    step();
    step();
    n_total++;
    if (!(err_c1 === 1'b1 && err_c2 === 1'b1 && err_cnt === 8'd2))
      $display("FAIL sat_double: got e1=%b e2=%b cnt=%0d want 1 1 2", err_c1, err_c2, err_cnt);
    else n_pass++;
    for (int i = 0; i < 200; i++) step();
    n_total++;
    if (err_cnt !== 8'hFF) $display("FAIL sat_value: got %0d want 255", err_cnt);
    else n_pass++;
    err_clr = 1;
    step();
    err_clr = 0;
    n_total++;
    if (err_cnt !== 8'd2) $display("FAIL sat_clr_new: got %0d want 2", err_cnt);
    else n_pass++;
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    c2_out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      c1_in_valid = 1;
      c1_in_data  = 9'h110 + DW'(k);
      step();
    end
    c1_in_valid = 0;
    step();
    rst_n = 0;
    #1;
    n_total++;
    if ({c1_out_valid, c2_out_valid, p_out_valid} !== 3'b000)
      $display("FAIL midrst_valid: got %b want 000", {c1_out_valid, c2_out_valid, p_out_valid});
    else n_pass++;
    step();
    rst_n = 1;
    c2_out_ready = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (c1_out_valid || c2_out_valid || p_out_valid) seen = 1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL midrst_stale: got %b want 0", seen);
    else n_pass++;
  endtask

  task automatic test_random();
    bit [2:0]      v, acc;
    logic [DW-1:0] d [3];
    do_reset();
    v = '0;
    for (int i = 0; i < 3; i++) d[i] = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!v[i]) begin
          v[i] = ($urandom_range(0, 2) != 0);
          d[i] = DW'($urandom);
        end
      end
      c1_in_valid = v[0]; c1_in_data = d[0];
      c2_in_valid = v[1]; c2_in_data = d[1];
      p_in_valid  = v[2]; p_in_data  = d[2];
      c1_out_ready = ($urandom_range(0, 3) != 0);
      c2_out_ready = ($urandom_range(0, 3) != 0);
      p_out_ready  = ($urandom_range(0, 3) != 0);
      err_clr = (cyc < 1500) && ($urandom_range(0, 63) == 0);
      acc = v & {p_in_ready, c2_in_ready, c1_in_ready};
      step();
      v = v & ~acc;
      n_total++;
      if ({p_out_valid, c2_out_valid, c1_out_valid} !== {m_oval[2], m_oval[1], m_oval[0]})
        $display("FAIL rnd_valid@%0d: got %b want %b", cyc,
                 {p_out_valid, c2_out_valid, c1_out_valid}, {m_oval[2], m_oval[1], m_oval[0]});
      else n_pass++;
      if (m_oval[0]) begin
        n_total++;
        if (c1_out_data !== m_odata[0])
          $display("FAIL rnd_c1_data@%0d: got %h want %h", cyc, c1_out_data, m_odata[0]);
        else n_pass++;
      end
      if (m_oval[1]) begin
        n_total++;
        if (c2_out_data !== m_odata[1])
          $display("FAIL rnd_c2_data@%0d: got %h want %h", cyc, c2_out_data, m_odata[1]);
        else n_pass++;
      end
      if (m_oval[2]) begin
        n_total++;
        if (p_out_data !== m_odata[2])
          $display("FAIL rnd_p_data@%0d: got %h want %h", cyc, p_out_data, m_odata[2]);
        else n_pass++;
      end
      n_total++;
      if ({p_in_ready, c2_in_ready, c1_in_ready} !==
          {mq[2].size() < DEPTH, mq[1].size() < DEPTH, mq[0].size() < DEPTH})
        $display("FAIL rnd_ready@%0d: got %b want sizes %0d %0d %0d", cyc,
                 {p_in_ready, c2_in_ready, c1_in_ready}, mq[2].size(), mq[1].size(),
                 mq[0].size());
      else n_pass++;
      n_total++;
      if ({err_c2, err_c1} !== m_err || int'(err_cnt) !== m_cnt)
        $display("FAIL rnd_err@%0d: got e=%b cnt=%0d want e=%b cnt=%0d", cyc,
                 {err_c2, err_c1}, err_cnt, m_err, m_cnt);
      else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_route_c1();
    test_route_p();
    test_back_to_back();
    test_backpressure();
    test_parity();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
